// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serialises a valid/ready word stream onto ccff_head,
// gates the chain clock so it shifts only on real bits, then recirculates the chain
// once through ccff_tail and compares a CRC of what came out with a CRC of what went in.
module ccff_bitstream_loader #(
  parameter  int CHAIN_LEN = 48,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int WC_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bits_left;   // LOAD: bits still to present; VERIFY: enables still to issue
  logic [WC_W-1:0]   word_left;   // bits of the current word not yet presented
  logic [WORD_W-1:0] shreg;       // remaining bits of the current word, MSB first
  logic              head_bit;    // registered bit presented to the chain head
  logic [15:0]       crc_load;
  logic [15:0]       crc_chk;

  // One CRC-16-CCITT step (poly 0x1021), one bit at a time.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    crc_step = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // A new word is taken only when the previous one is fully presented and bits remain.
  assign bs_ready  = (state == S_LOAD) && (word_left == '0) && (bits_left != '0);
  // During verification the chain feeds back on itself so its contents survive.
  assign ccff_head = (state == S_VERIFY) ? ccff_tail : head_bit;

  // Controller: sequencing, serialisation, clock gating and both CRCs.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state       <= S_IDLE;
      bits_left   <= '0;
      word_left   <= '0;
      shreg       <= '0;
      head_bit    <= 1'b0;
      prog_clk_en <= 1'b0;
      crc_load    <= '0;
      crc_chk     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state       <= S_LOAD;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            bits_left   <= CNT_W'(CHAIN_LEN);
            word_left   <= '0;
            shreg       <= '0;
            prog_clk_en <= 1'b0;
            crc_load    <= 16'hFFFF;
            crc_chk     <= 16'hFFFF;
          end
        end

        S_LOAD: begin
          if (bits_left == '0) begin
            // Last bit shifts in on this edge; any unused word bits are dropped.
            state       <= S_VERIFY;
            prog_clk_en <= 1'b0;
            word_left   <= '0;
            bits_left   <= CNT_W'(CHAIN_LEN);
          end else if (word_left != '0) begin
            head_bit    <= shreg[WORD_W-1];
            shreg       <= shreg << 1;
            word_left   <= word_left - WC_W'(1);
            bits_left   <= bits_left - CNT_W'(1);
            prog_clk_en <= 1'b1;
            crc_load    <= crc_step(crc_load, shreg[WORD_W-1]);
          end else if (bs_valid) begin
            head_bit    <= bs_data[WORD_W-1];
            shreg       <= bs_data << 1;
            word_left   <= WC_W'(WORD_W - 1);
            bits_left   <= bits_left - CNT_W'(1);
            prog_clk_en <= 1'b1;
            crc_load    <= crc_step(crc_load, bs_data[WORD_W-1]);
          end else begin
            // Starved: hold the head bit and stop the chain clock.
            prog_clk_en <= 1'b0;
          end
        end

        S_VERIFY: begin
          if (prog_clk_en) begin
            crc_chk <= crc_step(crc_chk, ccff_tail);
          end
          if (bits_left != '0) begin
            prog_clk_en <= 1'b1;
            bits_left   <= bits_left - CNT_W'(1);
          end else begin
            prog_clk_en <= 1'b0;
            if (prog_clk_en) begin
              state <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          busy  <= 1'b0;
          done  <= (crc_chk == crc_load);
          error <= (crc_chk != crc_load);
          state <= (crc_chk == crc_load) ? S_DONE : S_ERROR;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: two instances (48-bit and 13-bit chains), each
// with a behavioural shift-chain model; expected images come from the word stream.
module tb_ccff_bitstream_loader;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic pReset;

  // 48-bit chain instance
  logic       start_a, valid_a;
  logic [7:0] data_a;
  logic       ready_a, head_a, tail_a, en_a, busy_a, done_a, error_a;

  // 13-bit chain instance
  logic       start_b, valid_b;
  logic [7:0] data_b;
  logic       ready_b, head_b, tail_b, en_b, busy_b, done_b, error_b;

  ccff_bitstream_loader #(.CHAIN_LEN(48), .WORD_W(8)) dut_a (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_a), .bs_data(data_a),
    .bs_valid(valid_a), .bs_ready(ready_a), .ccff_head(head_a), .ccff_tail(tail_a),
    .prog_clk_en(en_a), .busy(busy_a), .done(done_a), .error(error_a)
  );

  ccff_bitstream_loader #(.CHAIN_LEN(13), .WORD_W(8)) dut_b (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_b), .bs_data(data_b),
    .bs_valid(valid_b), .bs_ready(ready_b), .ccff_head(head_b), .ccff_tail(tail_b),
    .prog_clk_en(en_b), .busy(busy_b), .done(done_b), .error(error_b)
  );

  // Chain models: shift toward the tail on every gated clock edge.
  logic [47:0] chain_a = '0;
  logic [12:0] chain_b = '0;
  logic        flip_a  = 1'b0;
  assign tail_a = chain_a[47];
  assign tail_b = chain_b[12];

  always @(posedge prog_clk) begin
    logic [47:0] nxt;
    nxt = chain_a;
    if (en_a) nxt = {chain_a[46:0], head_a};
    if (flip_a) nxt[47] = ~nxt[47];
    chain_a <= nxt;
  end

  always @(posedge prog_clk) begin
    if (en_b) chain_b <= {chain_b[11:0], head_b};
  end

  // Running activity counters, sampled mid-cycle.
  int en_tot_a = 0, busy_tot_a = 0, en_tot_b = 0, xfer_b = 0;
  always @(negedge prog_clk) begin
    if (en_a) en_tot_a++;
    if (busy_a) busy_tot_a++;
    if (en_b) en_tot_b++;
    if (valid_b && ready_b) xfer_b++;
  end

  int total = 0, bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] words[6];
  int         gaps[6];

  // Chain image after loading n bits: first bit ends up nearest the tail.
  function automatic logic [63:0] image_of(input int n);
    logic [63:0] img;
    img = '0;
    for (int i = 0; i < n; i++) img[n-1-i] = words[i/8][7-(i%8)];
    return img;
  endfunction

  // Full load/verify on the 48-bit instance; gaps[i] = cycles valid is held back
  // after the loader is ready for word i.
  task automatic run_a(input string tag, input bit do_flip, input bit start_mid);
    int en0, busy0, t, stall;
    en0 = en_tot_a;
    busy0 = busy_tot_a;
    stall = 0;
    @(negedge prog_clk) start_a = 1'b1;
    @(negedge prog_clk) start_a = 1'b0;
    check_eq({tag, " entry"}, {busy_a, done_a, error_a}, 3'b100);
    for (int i = 0; i < 6; i++) begin
      data_a  = words[i];
      valid_a = (gaps[i] == 0);
      t = 0;
      while (!ready_a && t < 100) begin @(negedge prog_clk); t++; end
      if (!ready_a) check_eq({tag, " ready timeout"}, 0, 1);
      if (gaps[i] > 0) begin
        repeat (gaps[i]) @(negedge prog_clk);
        stall += gaps[i];
        valid_a = 1'b1;
      end
      @(negedge prog_clk);
    end
    valid_a = 1'b0;
    if (do_flip || start_mid) begin
      repeat (20) @(negedge prog_clk);
      if (do_flip) flip_a = 1'b1;
      if (start_mid) start_a = 1'b1;
      @(negedge prog_clk);
      flip_a  = 1'b0;
      start_a = 1'b0;
    end
    t = 0;
    while (busy_a && t < 500) begin @(negedge prog_clk); t++; end
    if (busy_a) check_eq({tag, " busy timeout"}, 0, 1);
    check_eq({tag, " en cycles"}, en_tot_a - en0, 96);
    check_eq({tag, " busy cycles"}, busy_tot_a - busy0, 2*48 + 3 + stall);
    check_eq({tag, " flags"}, {busy_a, done_a, error_a}, {1'b0, !do_flip, do_flip});
    if (!do_flip) check_eq({tag, " image"}, chain_a, image_of(48));
    $display("run %s: done=%0b error=%0b busy_cycles=%0d image=0x%012h",
             tag, done_a, error_a, busy_tot_a - busy0, chain_a);
  endtask

  task automatic set_case1(input int gap);
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    words[3] = 8'h00; words[4] = 8'h81; words[5] = 8'h7E;
    for (int i = 0; i < 6; i++) gaps[i] = (i == 0) ? 0 : gap;
  endtask

  initial begin
    int t;
    pReset = 1'b0;
    start_a = 1'b0; valid_a = 1'b0; data_a = '0;
    start_b = 1'b0; valid_b = 1'b0; data_b = '0;
    #12;
    check_eq("reset a", {ready_a, head_a, en_a, busy_a, done_a, error_a}, 6'b0);
    check_eq("reset b", {ready_b, head_b, en_b, busy_b, done_b, error_b}, 6'b0);
    @(negedge prog_clk) pReset = 1'b1;

    // Case 1: streaming, no stalls
    set_case1(0);
    run_a("case1", 1'b0, 1'b0);
    check_eq("case1 literal image", chain_a, 48'hA53CFF00817E);

    // Case 2: valid withheld 5 cycles before every word after the first
    set_case1(5);
    run_a("case2 gaps", 1'b0, 1'b0);

    // Randomised words and stalls
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        words[i] = 8'($urandom_range(0, 255));
        gaps[i]  = $urandom_range(0, 3);
      end
      run_a($sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    // Case 3: corrupt the chain while it recirculates
    set_case1(0);
    run_a("case3 flip", 1'b1, 1'b0);

    // Case 4: short chain with a partial final word, valid held throughout
    words[0] = 8'hFF; words[1] = 8'hF8;
    data_b = words[0];
    valid_b = 1'b1;
    repeat (3) @(negedge prog_clk);
    check_eq("case4 idle xfer", xfer_b, 0);
    begin
      int en0;
      en0 = en_tot_b;
      start_b = 1'b1;
      @(negedge prog_clk) start_b = 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_b = words[i];
        t = 0;
        while (!ready_b && t < 50) begin @(negedge prog_clk); t++; end
        if (!ready_b) check_eq("case4 ready timeout", 0, 1);
        @(negedge prog_clk);
      end
      t = 0;
      while (busy_b && t < 200) begin @(negedge prog_clk); t++; end
      if (busy_b) check_eq("case4 busy timeout", 0, 1);
      repeat (3) @(negedge prog_clk);
      check_eq("case4 xfers", xfer_b, 2);
      check_eq("case4 en cycles", en_tot_b - en0, 26);
      check_eq("case4 image", chain_b, 13'h1FFF);
      check_eq("case4 image model", chain_b, image_of(13));
      check_eq("case4 flags", {busy_b, done_b, error_b}, 3'b010);
      $display("run case4: done=%0b error=%0b image=0x%04h", done_b, error_b, chain_b);
    end
    valid_b = 1'b0;

    // Case 5: asynchronous reset while bit 20 is on the head
    set_case1(0);
    @(negedge prog_clk) start_a = 1'b1;
    @(negedge prog_clk) start_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_a = words[i];
      valid_a = 1'b1;
      t = 0;
      while (!ready_a && t < 50) begin @(negedge prog_clk); t++; end
      @(negedge prog_clk);
    end
    repeat (3) @(negedge prog_clk);
    check_eq("case5 pre-reset", {busy_a, en_a, head_a}, 3'b111);
    #1 pReset = 1'b0;
    #1 check_eq("case5 async reset", {ready_a, head_a, en_a, busy_a, done_a, error_a}, 6'b0);
    valid_a = 1'b0;
    @(negedge prog_clk) pReset = 1'b1;
    $display("run case5: reset mid-load");
    run_a("case5 reload", 1'b0, 1'b0);

    // Case 6: start pulsed during verification, then a fresh start from DONE
    run_a("case6 start mid", 1'b0, 1'b1);
    run_a("case6 restart", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
